// File: rtl/i2cmb_rtl_pkg.sv
// Shared types for the I2CMB command sequencer: opcodes, completion status
// codes and the dispatcher state encoding.
package i2cmb_rtl_pkg;

  typedef enum logic [2:0] {
    OP_WAIT    = 3'b000,
    OP_WRITE   = 3'b001,
    OP_RD_ACK  = 3'b010,
    OP_RD_NAK  = 3'b011,
    OP_START   = 3'b100,
    OP_STOP    = 3'b101,
    OP_SET_BUS = 3'b110
  } i2cmb_op_t;

  typedef enum logic [1:0] {
    ST_DONE = 2'b00,
    ST_NAK  = 2'b01,
    ST_AL   = 2'b10,
    ST_ERR  = 2'b11
  } i2cmb_status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETBUS,
    S_ISSUE,
    S_WAIT,
    S_PUSH,
    S_FLUSH
  } seq_state_t;

  function automatic logic is_read(input i2cmb_op_t op);
    return (op == OP_RD_ACK) || (op == OP_RD_NAK);
  endfunction

endpackage

// File: rtl/i2cmb_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and single-cycle flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module i2cmb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/i2cmb_cmd_sequencer.sv
// Command queue and dispatcher in front of the I2CMB byte controller: inserts
// SET_BUS on bus changes, serialises commands and queues one response each.
module i2cmb_cmd_sequencer
  import i2cmb_rtl_pkg::*;
#(
  parameter int NUM_BUSES   = 16,
  parameter int DATA_W      = 8,
  parameter int CMD_DEPTH   = 8,
  parameter int RSP_DEPTH   = 8,
  parameter int FLUSH_ON_AL = 1,
  localparam int BUS_W = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1,
  localparam int CNT_W = $clog2(CMD_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [BUS_W-1:0]  cmd_bus_i,
  output logic              bc_cmd_valid_o,
  input  logic              bc_cmd_ready_i,
  output logic [2:0]        bc_cmd_op_o,
  output logic [DATA_W-1:0] bc_cmd_data_o,
  input  logic              bc_done_i,
  input  logic [1:0]        bc_status_i,
  input  logic [DATA_W-1:0] bc_rdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [1:0]        rsp_status_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [BUS_W-1:0]  rsp_bus_o,
  input  logic              abort_i,
  output logic              busy_o,
  output logic [BUS_W-1:0]  cur_bus_o,
  output logic [CNT_W-1:0]  cmd_count_o,
  output logic              irq_o
);

  typedef struct packed {
    i2cmb_op_t         op;
    logic [DATA_W-1:0] data;
    logic [BUS_W-1:0]  bus;
  } cmd_entry_t;

  typedef struct packed {
    i2cmb_status_t     status;
    logic [DATA_W-1:0] data;
    logic [BUS_W-1:0]  bus;
  } rsp_entry_t;

  function automatic logic [DATA_W-1:0] bus_to_data(input logic [BUS_W-1:0] b);
    return DATA_W'(b);
  endfunction

  seq_state_t state, state_nx;
  cmd_entry_t cmd_in, head, iss;
  rsp_entry_t lat, rsp_out;
  logic [BUS_W-1:0] cur_bus;
  logic cmd_full, cmd_empty, cmd_push, cmd_pop, cmd_flush;
  logic rsp_full, rsp_empty, rsp_push;
  logic auto_sb, abort_pend, abort_now, done_ok;
  logic [$clog2(RSP_DEPTH):0] rsp_count_unused;

  assign cmd_in    = '{op: i2cmb_op_t'(cmd_op_i), data: cmd_data_i, bus: cmd_bus_i};
  assign cmd_push  = cmd_valid_i && cmd_ready_o;
  assign abort_now = abort_pend || abort_i;
  assign done_ok   = (bc_status_i == ST_DONE);

  i2cmb_sync_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk_i), .rst(rst_i), .push(cmd_push), .pop(cmd_pop), .flush(cmd_flush),
    .din(cmd_in), .dout(head), .full(cmd_full), .empty(cmd_empty), .count(cmd_count_o)
  );

  i2cmb_sync_fifo #(.WIDTH($bits(rsp_entry_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk(clk_i), .rst(rst_i), .push(rsp_push), .pop(rsp_valid_o && rsp_ready_i), .flush(1'b0),
    .din(lat), .dout(rsp_out), .full(rsp_full), .empty(rsp_empty), .count(rsp_count_unused)
  );

  always_comb begin
    state_nx  = state;
    cmd_pop   = 1'b0;
    cmd_flush = 1'b0;
    rsp_push  = 1'b0;
    case (state)
      S_IDLE: begin
        if (abort_i) state_nx = S_FLUSH;
        else if (!cmd_empty)
          state_nx = (head.bus != cur_bus && head.op != OP_SET_BUS) ? S_SETBUS : S_ISSUE;
      end
      S_SETBUS: begin
        if (bc_cmd_ready_i) state_nx = S_WAIT;
        else if (abort_i)   state_nx = S_FLUSH;
      end
      S_ISSUE: begin
        if (bc_cmd_ready_i) begin
          cmd_pop  = 1'b1;
          state_nx = S_WAIT;
        end else if (abort_i) begin
          state_nx = S_FLUSH;
        end
      end
      S_WAIT: begin
        if (bc_done_i) begin
          if (auto_sb && done_ok) begin
            state_nx = abort_now ? S_FLUSH : S_ISSUE;
          end else begin
            // A failed auto SET_BUS consumes the head so it is answered once
            cmd_pop  = auto_sb;
            state_nx = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        if (!rsp_full) begin
          rsp_push = 1'b1;
          state_nx = (abort_now || (lat.status == ST_AL && FLUSH_ON_AL != 0)) ? S_FLUSH : S_IDLE;
        end
      end
      S_FLUSH: begin
        cmd_flush = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      cur_bus    <= '0;
      auto_sb    <= 1'b0;
      abort_pend <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      state <= state_nx;
      irq_o <= rsp_push;
      if (state == S_SETBUS && bc_cmd_ready_i) auto_sb <= 1'b1;
      if (state == S_WAIT && bc_done_i) begin
        auto_sb <= 1'b0;
        if (auto_sb && done_ok)                          cur_bus <= head.bus;
        else if (!auto_sb && done_ok && iss.op == OP_SET_BUS) cur_bus <= BUS_W'(iss.data);
      end
      if (state == S_FLUSH) abort_pend <= 1'b0;
      else if (abort_i && (state == S_WAIT || state == S_PUSH)) abort_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == S_ISSUE && bc_cmd_ready_i) iss <= head;
    if (state == S_WAIT && bc_done_i) begin
      lat.status <= i2cmb_status_t'(bc_status_i);
      lat.data   <= (!auto_sb && is_read(iss.op)) ? bc_rdata_i : '0;
      lat.bus    <= auto_sb ? head.bus : iss.bus;
    end
  end

  // FIFO storage is unreset, so everything sourced from it is qualified
  assign cmd_ready_o    = !rst_i && !cmd_full && (state != S_FLUSH);
  assign bc_cmd_valid_o = (state == S_SETBUS) || (state == S_ISSUE);
  assign bc_cmd_op_o    = (state == S_SETBUS) ? OP_SET_BUS :
                          (state == S_ISSUE)  ? head.op    : 3'b000;
  assign bc_cmd_data_o  = (state == S_SETBUS) ? bus_to_data(head.bus) :
                          (state == S_ISSUE)  ? head.data             : '0;
  assign rsp_valid_o    = !rsp_empty;
  assign rsp_status_o   = rsp_valid_o ? rsp_out.status : 2'b00;
  assign rsp_data_o     = rsp_valid_o ? rsp_out.data   : '0;
  assign rsp_bus_o      = rsp_valid_o ? rsp_out.bus    : '0;
  assign busy_o         = (state != S_IDLE) || !cmd_empty;
  assign cur_bus_o      = cur_bus;

endmodule
